// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing a mux_4_1 datapath among four valid/ready requesters; one-cycle latency into a one-entry output register, 1 word/cycle.
// A stalled output drops every in_ready. Optional saturating per-requester grant counters when MUX_ARB_CNT_EN is defined.

// 4-bit 4:1 mux slice.
module mux_4_1 (
   input  logic [3:0] i_d0,
   input  logic [3:0] i_d1,
   input  logic [3:0] i_d2,
   input  logic [3:0] i_d3,
   input  logic [1:0] i_sel,
   output logic [3:0] o_y
);
   always_comb begin
      o_y = i_d0;
      case (i_sel)
         2'd0: o_y = i_d0;
         2'd1: o_y = i_d1;
         2'd2: o_y = i_d2;
         2'd3: o_y = i_d3;
         default: o_y = i_d0;
      endcase
   end
endmodule

module mux_4_1_rr_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         in_valid,
   input  logic [WIDTH-1:0]   in_data0,
   input  logic [WIDTH-1:0]   in_data1,
   input  logic [WIDTH-1:0]   in_data2,
   input  logic [WIDTH-1:0]   in_data3,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_src,
   input  logic               out_ready,
   input  logic               cnt_clr,
   output logic [4*CNT_W-1:0] grant_cnt
);
   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_ptr;
   logic [WIDTH-1:0] r_data;
   logic [1:0]       r_src;
   logic [1:0]       w_grant;
   logic             w_found;
   logic             w_any;
   logic             w_space;
   logic             w_accept;
   logic [WIDTH-1:0] w_mux;

   // First valid requester at or after the priority pointer.
   always_comb begin
      w_grant = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!w_found && in_valid[r_ptr + 2'(k)]) begin
            w_grant = r_ptr + 2'(k);
            w_found = 1'b1;
         end
      end
   end

   assign w_any    = |in_valid;
   assign w_space  = (r_state == S_EMPTY) | out_ready;
   assign w_accept = w_any & w_space;

   genvar s;
   generate
      for (s = 0; s < WIDTH / 4; s++) begin : g_slice
         mux_4_1 u_mux (
            .i_d0  (in_data0[4*s +: 4]),
            .i_d1  (in_data1[4*s +: 4]),
            .i_d2  (in_data2[4*s +: 4]),
            .i_d3  (in_data3[4*s +: 4]),
            .i_sel (w_grant),
            .o_y   (w_mux[4*s +: 4])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL: begin
            if (w_accept)       w_state_nxt = S_FULL;
            else if (out_ready) w_state_nxt = S_EMPTY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // in_ready is masked during reset since the empty state would otherwise advertise space.
   always_comb begin
      out_valid = (r_state == S_FULL);
      in_ready  = 4'b0000;
      if (rst_n && w_accept) in_ready[w_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= 2'd0;
         r_data <= '0;
         r_src  <= 2'd0;
      end else if (w_accept) begin
         r_ptr  <= w_grant + 2'd1;
         r_data <= w_mux;
         r_src  <= w_grant;
      end
   end

   assign out_data = r_data;
   assign out_src  = r_src;

`ifdef MUX_ARB_CNT_EN
   logic [CNT_W-1:0] r_cnt [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (cnt_clr) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (w_accept && (r_cnt[w_grant] != {CNT_W{1'b1}})) begin
         r_cnt[w_grant] <= r_cnt[w_grant] + 1'b1;
      end
   end

   genvar c;
   generate
      for (c = 0; c < 4; c++) begin : g_cnt
         assign grant_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
      end
   endgenerate
`else
   logic w_cnt_clr_unused;
   assign w_cnt_clr_unused = cnt_clr;
   assign grant_cnt        = '0;
`endif
endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Scoreboard bench for mux_4_1_rr_arbiter: a small reference model pushes expected words on accept and pops them at consumer take.
module tb_mux_4_1_rr_arbiter;
   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic [3:0]         in_valid = 4'b0;
   logic [WIDTH-1:0]   in_data0 = '0;
   logic [WIDTH-1:0]   in_data1 = '0;
   logic [WIDTH-1:0]   in_data2 = '0;
   logic [WIDTH-1:0]   in_data3 = '0;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_src;
   logic               out_ready = 1'b0;
   logic               cnt_clr = 1'b0;
   logic [4*CNT_W-1:0] grant_cnt;

   always #5 clk = ~clk;

   mux_4_1_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .cnt_clr   (cnt_clr),
      .grant_cnt (grant_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [1:0] m_ptr = 2'd0;
   logic       m_full = 1'b0;
   logic [1:0] m_g;
   logic       m_acc, m_take, m_clr;
   logic [3:0] m_exp_ready;
   logic [3:0] m_d [4];
   int         m_cnt [4];
   logic [5:0] sb [$];
   logic [5:0] exp_w;

   function automatic logic [4*CNT_W-1:0] exp_cnt();
      logic [4*CNT_W-1:0] e = '0;
`ifdef MUX_ARB_CNT_EN
      for (int i = 0; i < 4; i++) e[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
      return e;
   endfunction

   task automatic model_reset();
      m_ptr = 2'd0;
      m_full = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
   endtask

   // Drive one cycle of inputs and predict this cycle's handshake.
   task automatic set_in(input logic [3:0] v, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3, input logic ordy, input logic clr);
      logic [1:0] idx;
      in_valid = v; in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
      out_ready = ordy; cnt_clr = clr;
      m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = d3; m_clr = clr;
      m_acc = 1'b0; m_g = m_ptr;
      for (int k = 0; k < 4; k++) begin
         idx = m_ptr + 2'(k);
         if (!m_acc && v[idx]) begin m_g = idx; m_acc = 1'b1; end
      end
      m_acc = m_acc && (!m_full || ordy);
      m_exp_ready = m_acc ? (4'b0001 << m_g) : 4'b0000;
      m_take = m_full && ordy;
      #1;
   endtask

   task automatic advance();
      @(posedge clk); #1;
      if (m_clr) begin
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (m_acc && m_cnt[m_g] < (2**CNT_W - 1)) begin
         m_cnt[m_g]++;
      end
      if (m_acc) begin
         sb.push_back({m_g, m_d[m_g]});
         m_ptr = m_g + 2'd1;
      end
      m_full = m_acc ? 1'b1 : (m_take ? 1'b0 : m_full);
   endtask

   task automatic test_reset();
      in_valid = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      n_checks++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
      n_checks++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL rst_grant_cnt: got %h want 0", grant_cnt); end
      @(posedge clk); @(posedge clk); #1;
      in_valid = 4'b0000;
      rst_n = 1'b1;
      model_reset();
      // Load a word from requester 1 and leave it stalled in the output register.
      set_in(4'b0010, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 1'b0);
      n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL rst_load_ready: got %b want %b", in_ready, m_exp_ready); end
      advance();
      n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h9) begin
         n_fail++; $display("FAIL rst_loaded: got v=%b src=%0d d=%h want v=1 src=1 d=9", out_valid, out_src, out_data); end
      in_valid = 4'b1111;
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
         n_fail++; $display("FAIL rst_async: got v=%b src=%0d d=%h want v=0 src=0 d=0", out_valid, out_src, out_data); end
      n_checks++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL rst_async_ready: got %b want 0000", in_ready); end
      model_reset();
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b want 0001", in_ready); end
      set_in(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      advance();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", out_valid); end
   endtask

   task automatic test_skip();
      logic [1:0] want_src [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      logic [3:0] want_dat [4] = '{4'hA, 4'h5, 4'hA, 4'h5};
      for (int i = 0; i < 5; i++) begin
         set_in((i < 4) ? 4'b1010 : 4'b0000, 4'h0, 4'hA, 4'h0, 4'h5, 1'b1, 1'b0);
         n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL skip_ready[%0d]: got %b want %b", i, in_ready, m_exp_ready); end
         if (m_take) begin
            exp_w = sb.pop_front();
            n_checks++; if ({out_src, out_data} !== exp_w) begin n_fail++; $display("FAIL skip_take[%0d]: got %h want %h", i, {out_src, out_data}, exp_w); end
         end
         advance();
         n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL skip_valid[%0d]: got %b want %b", i, out_valid, m_full); end
         if (i < 4) begin
            n_checks++; if (out_src !== want_src[i] || out_data !== want_dat[i]) begin
               n_fail++; $display("FAIL skip_seq[%0d]: got src=%0d d=%h want src=%0d d=%h", i, out_src, out_data, want_src[i], want_dat[i]); end
         end
      end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 6; i++) begin
         set_in((i < 5) ? 4'b1111 : 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 1'b0);
         n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, m_exp_ready); end
         if (i < 5) begin
            n_checks++; if (!$onehot(in_ready)) begin n_fail++; $display("FAIL rr_onehot[%0d]: got %b want one-hot", i, in_ready); end
         end
         if (m_take) begin
            exp_w = sb.pop_front();
            n_checks++; if ({out_src, out_data} !== exp_w) begin n_fail++; $display("FAIL rr_take[%0d]: got %h want %h", i, {out_src, out_data}, exp_w); end
         end
         advance();
         n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want %b", i, out_valid, m_full); end
         if (i < 5) begin
            n_checks++; if (out_src !== 2'(i % 4) || out_data !== 4'(i % 4 + 1)) begin
               n_fail++; $display("FAIL rr_seq[%0d]: got src=%0d d=%h want src=%0d", i, out_src, out_data, i % 4); end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [3:0] tv [7] = '{4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b0000};
      logic       tr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         set_in(tv[i], 4'h8, 4'h2, 4'h6, 4'h4, tr[i], 1'b0);
         n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, m_exp_ready); end
         if (i >= 1 && i <= 3) begin
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", i, in_ready); end
         end
         if (i == 5) begin
            n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_ptr_one: got %b want 0010", in_ready); end
         end
         if (m_take) begin
            exp_w = sb.pop_front();
            n_checks++; if ({out_src, out_data} !== exp_w) begin n_fail++; $display("FAIL bp_take[%0d]: got %h want %h", i, {out_src, out_data}, exp_w); end
         end
         advance();
         n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want %b", i, out_valid, m_full); end
         if (i <= 3) begin
            n_checks++; if (out_src !== 2'd2 || out_data !== 4'h6) begin
               n_fail++; $display("FAIL bp_stable[%0d]: got src=%0d d=%h want src=2 d=6", i, out_src, out_data); end
         end
      end
   endtask

   task automatic test_drain_accept();
      logic [3:0] tv [3] = '{4'b0001, 4'b0100, 4'b0000};
      logic       tr [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         set_in(tv[i], 4'h3, 4'h0, 4'h7, 4'h0, tr[i], 1'b0);
         n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL da_ready[%0d]: got %b want %b", i, in_ready, m_exp_ready); end
         if (m_take) begin
            exp_w = sb.pop_front();
            n_checks++; if ({out_src, out_data} !== exp_w) begin n_fail++; $display("FAIL da_take[%0d]: got %h want %h", i, {out_src, out_data}, exp_w); end
         end
         advance();
         n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL da_valid[%0d]: got %b want %b", i, out_valid, m_full); end
         if (i == 1) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h7 || out_src !== 2'd2) begin
               n_fail++; $display("FAIL da_reload: got v=%b src=%0d d=%h want v=1 src=2 d=7", out_valid, out_src, out_data); end
         end
      end
   endtask

   task automatic test_counters();
      logic [CNT_W-1:0] want_sat;
`ifdef MUX_ARB_CNT_EN
      want_sat = CNT_W'(3);
`else
      want_sat = '0;
`endif
      for (int i = 0; i < 7; i++) begin
         set_in((i < 6) ? 4'b0001 : 4'b0000, 4'hC, 4'h0, 4'h0, 4'h0, 1'b1, (i == 5) ? 1'b1 : 1'b0);
         n_checks++; if (in_ready !== m_exp_ready) begin n_fail++; $display("FAIL cnt_ready[%0d]: got %b want %b", i, in_ready, m_exp_ready); end
         if (m_take) begin
            exp_w = sb.pop_front();
            n_checks++; if ({out_src, out_data} !== exp_w) begin n_fail++; $display("FAIL cnt_take[%0d]: got %h want %h", i, {out_src, out_data}, exp_w); end
         end
         advance();
         n_checks++; if (grant_cnt !== exp_cnt()) begin n_fail++; $display("FAIL cnt_value[%0d]: got %h want %h", i, grant_cnt, exp_cnt()); end
         if (i == 4) begin
            n_checks++; if (grant_cnt[CNT_W-1:0] !== want_sat) begin n_fail++; $display("FAIL cnt_sat: got %0d want %0d", grant_cnt[CNT_W-1:0], want_sat); end
         end
         if (i == 5) begin
            n_checks++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL cnt_clr: got %h want 0", grant_cnt); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_skip();
      test_round_robin();
      test_back_pressure();
      test_drain_accept();
      test_counters();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
